// File: rtl/uart_pkg.sv
// Shared UART definitions: default byte width, TX buffer FSM encodings and a
// constant-evaluable log2 helper for sizing pointers and counters.
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;

  typedef enum logic [1:0] {
    TXB_IDLE  = 2'd0,
    TXB_REQ   = 2'd1,
    TXB_DRAIN = 2'd2
  } txb_state_t;

  function automatic int uart_clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_tx_buffer_if.sv
// Producer-side write handshake, transmitter-side start/busy group and
// buffer status, bundled for the TX buffer.
interface uart_tx_buffer_if
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int DEPTH      = 16
);
  localparam int CNT_W = uart_clog2(DEPTH) + 1;

  logic                  wr_valid;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  wr_ready;
  logic                  flush;
  logic                  tx_busy;
  logic                  tx_start;
  logic [DATA_WIDTH-1:0] tx_data;
  logic [CNT_W-1:0]      fifo_count;
  logic                  full;
  logic                  empty;
  logic                  active;

  modport master (
    output wr_valid, wr_data, flush, tx_busy,
    input  wr_ready, tx_start, tx_data, fifo_count, full, empty, active
  );

  modport slave (
    input  wr_valid, wr_data, flush, tx_busy,
    output wr_ready, tx_start, tx_data, fifo_count, full, empty, active
  );

endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous show-ahead FIFO with registered count/full/empty and a
// synchronous clear; push is ignored when full, pop ignored when empty.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int DEPTH      = 16,
  parameter int CNT_W      = uart_clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic [CNT_W-1:0]      count,
  output logic                  full,
  output logic                  empty
);
  localparam int PTR_W = uart_clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  push_ok;
  logic                  pop_ok;
  logic [CNT_W-1:0]      count_nxt;

  assign push_ok  = push && !full;
  assign pop_ok   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (push_ok && !pop_ok)
      count_nxt = count + CNT_W'(1);
    else if (!push_ok && pop_ok)
      count_nxt = count - CNT_W'(1);
  end

  // Flags are registered from the next count so they line up with count.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)
        rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_nxt;
      full  <= (count_nxt == CNT_W'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok && !clr)
      mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/uart_tx_buffer.sv
// Buffered UART transmit front-end: queues producer bytes and launches them
// one at a time with a level tx_start / tx_busy handshake.
module uart_tx_buffer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int DEPTH      = 16
) (
  input  logic              clk,
  input  logic              rst,
  uart_tx_buffer_if.slave   bus
);
  localparam int CNT_W = uart_clog2(DEPTH) + 1;

  txb_state_t            state;
  logic                  pop;
  logic                  push;
  logic [DATA_WIDTH-1:0] head;
  logic [CNT_W-1:0]      count;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  start_q;
  logic [DATA_WIDTH-1:0] data_q;

  assign bus.wr_ready   = !fifo_full;
  assign push           = bus.wr_valid && !fifo_full;
  assign pop            = (state == TXB_IDLE) && !fifo_empty;
  assign bus.fifo_count = count;
  assign bus.full       = fifo_full;
  assign bus.empty      = fifo_empty;
  assign bus.tx_start   = start_q;
  assign bus.tx_data    = data_q;
  assign bus.active     = !fifo_empty || (state != TXB_IDLE);

  uart_sync_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .CNT_W     (CNT_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clr      (bus.flush),
    .push     (push),
    .push_data(bus.wr_data),
    .pop      (pop),
    .pop_data (head),
    .count    (count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // flush only clears the queue; a byte already latched here is still sent.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= TXB_IDLE;
      start_q <= 1'b0;
      data_q  <= '0;
    end else begin
      case (state)
        TXB_IDLE: begin
          if (!fifo_empty) begin
            data_q  <= head;
            start_q <= 1'b1;
            state   <= TXB_REQ;
          end
        end
        TXB_REQ: begin
          if (bus.tx_busy) begin
            start_q <= 1'b0;
            state   <= TXB_DRAIN;
          end
        end
        TXB_DRAIN: begin
          start_q <= 1'b0;
          if (!bus.tx_busy)
            state <= TXB_IDLE;
        end
        default: begin
          start_q <= 1'b0;
          state   <= TXB_IDLE;
        end
      endcase
    end
  end

endmodule
